// File: rtl/tt_pwm_pkg.sv
// Shared constants and types for the multi-channel PWM engine.
package tt_pwm_pkg;

    localparam int unsigned ADDR_PERIOD    = 0;
    localparam int unsigned ADDR_DUTY_BASE = 1;

    localparam int unsigned CTRL_MODE = 0;
    localparam int unsigned CTRL_RUN  = 1;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTRE = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } cnt_dir_e;

    function automatic int unsigned addr_ctrl(input int unsigned channels);
        return channels + 1;
    endfunction

endpackage

// File: rtl/tt_pwm_counter.sv
// Shared period counter: edge (0..P wrap) or centre (0..P..0 triangle) counting.
module tt_pwm_counter
    import tt_pwm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    input  pwm_mode_e        mode_i,
    input  logic [WIDTH-1:0] period_i,
    input  logic [WIDTH-1:0] period_nxt_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             boundary_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    cnt_dir_e         dir_q, dir_d;
    logic             boundary;

    always_comb begin
        boundary = 1'b0;
        if (period_i == '0) begin
            boundary = 1'b1;
        end else if (mode_i == PWM_EDGE) begin
            boundary = (cnt_q >= period_i);
        end else begin
            boundary = (cnt_q == '0) && (dir_q == DirDown);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (clear_i) begin
            cnt_d = '0;
            dir_d = DirUp;
        end else if (en_i) begin
            if (period_i == '0) begin
                cnt_d = '0;
                dir_d = DirUp;
            end else if (mode_i == PWM_EDGE) begin
                cnt_d = boundary ? '0 : cnt_q + 1'b1;
                dir_d = DirUp;
            end else if (dir_q == DirUp) begin
                if (cnt_q >= period_i) begin
                    cnt_d = period_i - 1'b1;
                    dir_d = DirDown;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (cnt_q == '0) begin
                // Turnaround: the period about to become active decides whether we can climb.
                cnt_d = (period_nxt_i == '0) ? '0 : WIDTH'(1);
                dir_d = DirUp;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            dir_q <= DirUp;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign boundary_o = boundary;

endmodule

// File: rtl/tt_pwm_multi.sv
// Multi-channel PWM with double-buffered period/duty, edge or centre aligned.
module tt_pwm_multi
    import tt_pwm_pkg::*;
#(
    parameter  int unsigned CHANNELS = 4,
    parameter  int unsigned WIDTH    = 8,
    localparam int unsigned ADDR_W   = $clog2(CHANNELS + 2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick,
    output logic                busy
);

    logic [WIDTH-1:0]    period_stg_q, period_stg_d, period_act_q, period_act_d;
    logic                period_pend_q, period_pend_d;
    logic [WIDTH-1:0]    duty_stg_q [CHANNELS];
    logic [WIDTH-1:0]    duty_stg_d [CHANNELS];
    logic [WIDTH-1:0]    duty_act_q [CHANNELS];
    logic [WIDTH-1:0]    duty_act_d [CHANNELS];
    logic [CHANNELS-1:0] duty_pend_q, duty_pend_d;
    pwm_mode_e           mode_q, mode_d;
    logic                run_q, run_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                tick_q, tick_d;

    logic [WIDTH-1:0]    cnt;
    logic                boundary, xfer, ctrl_wr, period_wr, restart;

    assign period_wr = wr_en && (wr_addr == ADDR_W'(ADDR_PERIOD));
    assign ctrl_wr   = wr_en && (wr_addr == ADDR_W'(addr_ctrl(CHANNELS)));
    assign restart   = ctrl_wr && (pwm_mode_e'(wr_data[CTRL_MODE]) != mode_q);
    // Staging moves to active at a counted boundary, or continuously while stopped.
    assign xfer      = !run_q || (ena && boundary);

    always_comb begin
        period_stg_d  = period_wr ? wr_data : period_stg_q;
        period_act_d  = (xfer && period_pend_q) ? period_stg_q : period_act_q;
        period_pend_d = period_wr || (period_pend_q && !xfer);
        mode_d        = ctrl_wr ? pwm_mode_e'(wr_data[CTRL_MODE]) : mode_q;
        run_d         = ctrl_wr ? wr_data[CTRL_RUN] : run_q;
    end

    always_comb begin
        duty_stg_d  = duty_stg_q;
        duty_act_d  = duty_act_q;
        duty_pend_d = duty_pend_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (xfer && duty_pend_q[i]) duty_act_d[i] = duty_stg_q[i];
            if (xfer) duty_pend_d[i] = 1'b0;
            if (wr_en && (wr_addr == ADDR_W'(ADDR_DUTY_BASE + i))) begin
                duty_stg_d[i]  = wr_data;
                duty_pend_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        pwm_d  = pwm_q;
        tick_d = 1'b0;
        if (!run_q) begin
            pwm_d = '0;
        end else if (ena) begin
            for (int i = 0; i < CHANNELS; i++) pwm_d[i] = (cnt < duty_act_q[i]);
            tick_d = boundary;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_stg_q  <= '1;
            period_act_q  <= '1;
            period_pend_q <= 1'b0;
            duty_pend_q   <= '0;
            mode_q        <= PWM_EDGE;
            run_q         <= 1'b0;
            pwm_q         <= '0;
            tick_q        <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_stg_q[i] <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            period_stg_q  <= period_stg_d;
            period_act_q  <= period_act_d;
            period_pend_q <= period_pend_d;
            duty_pend_q   <= duty_pend_d;
            mode_q        <= mode_d;
            run_q         <= run_d;
            pwm_q         <= pwm_d;
            tick_q        <= tick_d;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_stg_q[i] <= duty_stg_d[i];
                duty_act_q[i] <= duty_act_d[i];
            end
        end
    end

    tt_pwm_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (!run_q || restart),
        .en_i        (ena),
        .mode_i      (mode_q),
        .period_i    (period_act_q),
        .period_nxt_i(period_act_d),
        .cnt_o       (cnt),
        .boundary_o  (boundary)
    );

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;
    assign busy        = period_pend_q || (|duty_pend_q);

endmodule

// File: tb/tb_tt_pwm_multi.sv
// Randomised and directed checks of tt_pwm_multi against a position-based reference model.
module tb_tt_pwm_multi;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int AW = 3;
    localparam logic [AW-1:0] ACTRL = 3'd5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic [CH-1:0] pwm_out;
    logic          period_tick;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    tt_pwm_multi #(
        .CHANNELS(CH),
        .WIDTH   (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pwm_out    (pwm_out),
        .period_tick(period_tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the current sweep rather than counter/direction.
    int           m_pos, m_p, m_pstg;
    bit           m_ppend;
    int           m_dact [CH];
    int           m_dstg [CH];
    bit [CH-1:0]  m_dpend;
    bit           m_mode, m_run, m_tick;
    bit [CH-1:0]  m_pwm;

    task automatic model_reset();
        m_pos = 0; m_p = 255; m_pstg = 255; m_ppend = 0;
        m_dpend = '0; m_mode = 0; m_run = 0; m_tick = 0; m_pwm = '0;
        for (int i = 0; i < CH; i++) begin
            m_dact[i] = 0;
            m_dstg[i] = 0;
        end
    endtask

    task automatic model_step();
        bit bnd, xfer, restart;
        bit [CH-1:0] npwm;
        bit ntick;
        int c, np, npos;
        bnd = (m_p == 0) || (m_mode ? (m_pos == 2 * m_p) : (m_pos == m_p));
        c   = (m_mode && m_pos > m_p) ? 2 * m_p - m_pos : m_pos;
        if (!m_run) begin
            npwm = '0; ntick = 0;
        end else if (ena) begin
            for (int i = 0; i < CH; i++) npwm[i] = (c < m_dact[i]);
            ntick = bnd;
        end else begin
            npwm = m_pwm; ntick = 0;
        end
        xfer    = !m_run || (ena && bnd);
        restart = wr_en && (wr_addr == ACTRL) && (wr_data[0] != m_mode);
        np      = (xfer && m_ppend) ? m_pstg : m_p;
        if (!m_run || restart)  npos = 0;
        else if (!ena)          npos = m_pos;
        else if (m_p == 0)      npos = 0;
        else if (bnd)           npos = (m_mode && np != 0) ? 1 : 0;
        else                    npos = m_pos + 1;
        m_p = np;
        if (xfer) m_ppend = 0;
        for (int i = 0; i < CH; i++) begin
            if (xfer && m_dpend[i]) m_dact[i] = m_dstg[i];
            if (xfer) m_dpend[i] = 0;
        end
        if (wr_en) begin
            if (wr_addr == 0) begin
                m_pstg = int'(wr_data); m_ppend = 1;
            end else if (wr_addr <= CH) begin
                m_dstg[int'(wr_addr) - 1] = int'(wr_data); m_dpend[int'(wr_addr) - 1] = 1;
            end else if (wr_addr == ACTRL) begin
                m_mode = wr_data[0]; m_run = wr_data[1];
            end
        end
        m_pwm = npwm; m_tick = ntick; m_pos = npos;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_pwm", 32'(pwm_out), 32'(m_pwm));
            chk("model_tick", 32'(period_tick), 32'(m_tick));
            chk("model_busy", 32'(busy), 32'(m_ppend || (|m_dpend)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = W'(d);
        step();
    endtask

    task automatic wait_tick(input string name);
        int k = 0;
        step();
        while (!period_tick && k < 40) begin
            step();
            k++;
        end
        chk(name, 32'(period_tick), 1);
    endtask

    task automatic count(input int n, output int h0, output int h1, output int h2, output int t);
        h0 = 0; h1 = 0; h2 = 0; t = 0;
        for (int i = 0; i < n; i++) begin
            step();
            h0 += int'(pwm_out[0]); h1 += int'(pwm_out[1]);
            h2 += int'(pwm_out[2]); t += int'(period_tick);
        end
    endtask

    task automatic first_tick_after(input string name, input int exp);
        int k = 0;
        while (!period_tick && k < 40) begin
            step();
            k++;
        end
        chk(name, k, exp);
    endtask

    initial begin
        int h0, h1, h2, t;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;
        chk("reset_pwm", 32'(pwm_out), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_tick", 32'(period_tick), 0);
        count(10, h0, h1, h2, t);
        chk("idle_pwm0", h0, 0);

        // Edge mode P=9: 3/7 on ch0, ch1 low, ch2 high, tick every 10.
        wr(0, 9); wr(1, 3); wr(2, 0); wr(3, 10); wr(5, 2);
        wait_tick("edge_first_tick");
        count(20, h0, h1, h2, t);
        chk("edge_ch0_high", h0, 6);
        chk("edge_ch1_high", h1, 0);
        chk("edge_ch2_high", h2, 20);
        chk("edge_ticks", t, 2);

        // Centre mode P=8: period 16, first tick 17 cycles after run.
        wr(5, 0); wr(0, 8); wr(1, 2); wr(5, 3);
        first_tick_after("centre_first_tick", 17);
        count(32, h0, h1, h2, t);
        chk("centre_ticks", t, 2);

        // Double-buffered duty update mid-period and on the boundary cycle.
        wr(5, 0); wr(0, 9); wr(1, 3); wr(5, 2);
        wait_tick("upd_tick");
        repeat (4) step();
        wr(1, 6);
        chk("upd_busy_set", 32'(busy), 1);
        for (int k = 0; k < 12 && busy; k++) step();
        chk("upd_busy_clear", 32'(busy), 0);
        count(20, h0, h1, h2, t);
        chk("upd_ch0_high", h0, 12);
        wait_tick("bnd_tick");
        repeat (9) step();
        wr(1, 2);
        chk("bnd_busy_set", 32'(busy), 1);
        repeat (9) step();
        chk("bnd_busy_held", 32'(busy), 1);
        step();
        chk("bnd_busy_clear", 32'(busy), 0);

        // P=0: tick every cycle, then frozen by ena.
        wr(5, 0); wr(0, 0); wr(1, 1); wr(5, 2);
        repeat (3) step();
        chk("p0_tick", 32'(period_tick), 1);
        chk("p0_pwm0", 32'(pwm_out[0]), 1);
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("frozen_tick", 32'(period_tick), 0);
            chk("frozen_pwm0", 32'(pwm_out[0]), 1);
        end
        ena = 1'b1;

        // Asynchronous reset mid-period in centre mode.
        wr(5, 0); wr(0, 8); wr(1, 2); wr(5, 3);
        repeat (7) step();
        rst = 1'b1;
        #2;
        chk("arst_pwm", 32'(pwm_out), 0);
        chk("arst_busy", 32'(busy), 0);
        step();
        rst = 1'b0;
        wr(0, 8); wr(1, 2); wr(5, 3);
        first_tick_after("rerun_first_tick", 17);

        for (int n = 0; n < 1500; n++) begin
            ena = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0) begin
                wr_en   = 1'b1;
                wr_addr = AW'($urandom_range(0, 7));
                if (wr_addr == 0) begin
                    wr_data = W'($urandom_range(0, 12));
                end else if (wr_addr == ACTRL) begin
                    wr_data    = '0;
                    wr_data[1] = ($urandom_range(0, 7) != 0);
                    wr_data[0] = 1'($urandom_range(0, 1));
                end else begin
                    wr_data = W'($urandom_range(0, 14));
                end
            end
            step();
        end
        ena = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
